// File: rtl/arc_ws_timing_gen.sv
// Word timing, sync window, serial instruction capture, pointer register and
// word-select decode for the serial ARC datapath.
module arc_ws_timing_gen #(
  parameter int unsigned DIGITS     = 14,
  parameter int unsigned DIGIT_BITS = 4,
  parameter int unsigned IS_BITS    = 10,
  parameter int unsigned EXP_DIGITS = 3,
  parameter int unsigned PTR_RST    = 3
) (
  input  logic                                   cph2,
  input  logic                                   rst,
  input  logic                                   ce,
  input  logic                                   is,
  output logic                                   sync,
  output logic                                   ws,
  output logic [$clog2(DIGITS*DIGIT_BITS)-1:0]   bit_cnt,
  output logic [$clog2(DIGITS)-1:0]              digit,
  output logic                                   word_end,
  output logic [IS_BITS-1:0]                     inst,
  output logic                                   inst_valid,
  output logic [$clog2(DIGITS)-1:0]              ptr,
  output logic                                   ptr_ovf
);

  localparam int unsigned W  = DIGITS * DIGIT_BITS;
  localparam int unsigned BW = $clog2(W);
  localparam int unsigned DW = $clog2(DIGITS);

  localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
  localparam logic [BW-1:0] SYNC_LO   = BW'(W - IS_BITS - 1);
  localparam logic [BW-1:0] SYNC_HI   = BW'(W - 2);
  localparam logic [BW-1:0] DIG_MASK  = BW'(DIGIT_BITS - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
  localparam logic [DW-1:0] DIG_MLAST = DW'(DIGITS - 2);
  localparam logic [DW-1:0] EXP_LO    = DW'(EXP_DIGITS);
  localparam logic [DW-1:0] EXP_HI    = DW'(EXP_DIGITS - 1);
  localparam logic [DW-1:0] PTR_INIT  = DW'(PTR_RST);

  localparam logic [3:0] OP_SET = 4'b1100;
  localparam logic [3:0] OP_INC = 4'b1101;
  localparam logic [3:0] OP_DEC = 4'b0111;

  logic [BW-1:0]      bit_cnt_q;
  logic [DW-1:0]      digit_q;
  logic [IS_BITS-1:0] sr_q;
  logic [IS_BITS-1:0] inst_q;
  logic               en_q;
  logic [2:0]         ftype_q;
  logic [DW-1:0]      ptr_q;
  logic               inst_valid_q;
  logic               ptr_ovf_q;

  logic digit_step;
  logic set_ok;

  assign word_end   = (bit_cnt_q == BIT_LAST);
  assign sync       = (bit_cnt_q >= SYNC_LO) && (bit_cnt_q <= SYNC_HI);
  assign digit_step = ((bit_cnt_q & DIG_MASK) == DIG_MASK);
  assign set_ok     = (32'(sr_q[9:6]) < DIGITS);

  always_ff @(posedge cph2) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      digit_q      <= '0;
      sr_q         <= '0;
      inst_q       <= '0;
      en_q         <= 1'b0;
      ftype_q      <= 3'b000;
      ptr_q        <= PTR_INIT;
      inst_valid_q <= 1'b0;
      ptr_ovf_q    <= 1'b0;
    end else if (ce) begin
      inst_valid_q <= word_end;
      ptr_ovf_q    <= 1'b0;
      if (word_end) begin
        bit_cnt_q <= '0;
        digit_q   <= '0;
      end else begin
        bit_cnt_q <= bit_cnt_q + BW'(1);
        if (digit_step) digit_q <= digit_q + DW'(1);
      end
      // First-received bit ends up in bit 0 once the window closes.
      if (sync) sr_q <= {is, sr_q[IS_BITS-1:1]};
      if (word_end) begin
        inst_q <= sr_q;
        en_q   <= (sr_q[1:0] == 2'b10);
        if (sr_q[1:0] == 2'b10) ftype_q <= sr_q[4:2];
        if (sr_q[1:0] == 2'b00) begin
          case (sr_q[5:2])
            OP_SET: begin
              if (set_ok) ptr_q <= DW'(sr_q[9:6]);
              else        ptr_ovf_q <= 1'b1;
            end
            OP_INC:  ptr_q <= (ptr_q == DIG_LAST) ? '0 : ptr_q + DW'(1);
            OP_DEC:  ptr_q <= (ptr_q == '0) ? DIG_LAST : ptr_q - DW'(1);
            default: ;
          endcase
        end
      end
    end else begin
      inst_valid_q <= 1'b0;
      ptr_ovf_q    <= 1'b0;
    end
  end

  always_comb begin
    ws = 1'b1;
    if (en_q) begin
      case (ftype_q)
        3'b000:  ws = (digit_q == ptr_q);
        3'b001:  ws = (digit_q >= EXP_LO) && (digit_q <= DIG_MLAST);
        3'b010:  ws = (digit_q <= EXP_HI);
        3'b011:  ws = 1'b1;
        3'b100:  ws = (digit_q <= ptr_q);
        3'b101:  ws = (digit_q >= EXP_LO);
        3'b110:  ws = (digit_q == EXP_HI);
        default: ws = (digit_q == DIG_LAST);
      endcase
    end
  end

  assign bit_cnt    = bit_cnt_q;
  assign digit      = digit_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign ptr        = ptr_q;
  assign ptr_ovf    = ptr_ovf_q;

endmodule

// File: tb/tb_arc_ws_timing_gen.sv
// Bench for arc_ws_timing_gen: directed scenarios plus randomized words checked
// against a position-indexed behavioural model.
module tb_arc_ws_timing_gen;

  localparam int DIG  = 14;
  localparam int DB   = 4;
  localparam int ISB  = 10;
  localparam int EXPD = 3;
  localparam int PRST = 3;
  localparam int W    = DIG * DB;
  localparam int LO   = W - ISB - 1;

  logic        cph2 = 1'b0;
  logic        rst, ce, is;
  logic        sync, ws, word_end, inst_valid, ptr_ovf;
  logic [5:0]  bit_cnt;
  logic [3:0]  digit, ptr;
  logic [9:0]  inst;

  arc_ws_timing_gen #(
    .DIGITS(DIG), .DIGIT_BITS(DB), .IS_BITS(ISB), .EXP_DIGITS(EXPD), .PTR_RST(PRST)
  ) dut (
    .cph2(cph2), .rst(rst), .ce(ce), .is(is), .sync(sync), .ws(ws),
    .bit_cnt(bit_cnt), .digit(digit), .word_end(word_end), .inst(inst),
    .inst_valid(inst_valid), .ptr(ptr), .ptr_ovf(ptr_ovf)
  );

  always #5 cph2 = ~cph2;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  int           m_pos;
  logic [9:0]   m_sr, m_inst;
  bit           m_en, m_iv, m_ovf, m_wrap;
  int           m_ft, m_ptr;

  function automatic bit in_sync(int p);
    return (p >= LO) && (p <= W - 2);
  endfunction

  function automatic logic exp_ws(int d);
    if (!m_en) return 1'b1;
    case (m_ft)
      0: return d == m_ptr;
      1: return (d >= EXPD) && (d <= DIG - 2);
      2: return d <= EXPD - 1;
      3: return 1'b1;
      4: return d <= m_ptr;
      5: return d >= EXPD;
      6: return d == EXPD - 1;
      default: return d == DIG - 1;
    endcase
  endfunction

  function automatic logic pick_is(logic [9:0] ins);
    if (in_sync(m_pos)) return ins[m_pos - LO];
    return logic'($urandom % 2);
  endfunction

  function automatic logic [9:0] rand_ins();
    case ($urandom % 5)
      0: return {5'($urandom), 3'($urandom), 2'b10};
      1: return {4'($urandom), 4'b1100, 2'b00};
      2: return {4'($urandom), 4'b1101, 2'b00};
      3: return {4'($urandom), 4'b0111, 2'b00};
      default: return 10'($urandom);
    endcase
  endfunction

  task automatic step(input bit r, input bit c, input logic i);
    int v, op;
    rst = r; ce = c; is = i;
    @(posedge cph2);
    m_wrap = 0;
    if (r) begin
      m_pos = 0; m_sr = '0; m_inst = '0; m_en = 0; m_ft = 0;
      m_ptr = PRST; m_iv = 0; m_ovf = 0;
    end else if (c) begin
      m_iv = 0; m_ovf = 0;
      if (in_sync(m_pos)) m_sr[m_pos - LO] = i;
      if (m_pos == W - 1) begin
        m_inst = m_sr; m_iv = 1;
        v = int'(m_inst[9:6]); op = int'(m_inst[5:2]);
        if (m_inst[1:0] == 2'b10) begin
          m_en = 1; m_ft = int'(m_inst[4:2]);
        end else begin
          m_en = 0;
          if (m_inst[1:0] == 2'b00) begin
            if (op == 12) begin
              if (v < DIG) m_ptr = v; else m_ovf = 1;
            end else if (op == 13) m_ptr = (m_ptr + 1) % DIG;
            else if (op == 7) m_ptr = (m_ptr + DIG - 1) % DIG;
          end
        end
      end
      m_pos = (m_pos + 1) % W;
      if (m_pos == 0) m_wrap = 1;
    end else begin
      m_iv = 0; m_ovf = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 1'b0);
    step(1, 1, 1'b1);
  endtask

  task automatic run_word(input logic [9:0] ins, output logic [W-1:0] seen);
    seen = '0;
    for (int k = 0; k < W; k++) begin
      seen[m_pos] = ws;
      step(0, 1, pick_is(ins));
    end
  endtask

  task automatic run_to(input logic [9:0] ins, input int target);
    while (m_pos != target) step(0, 1, pick_is(ins));
  endtask

  task automatic test_reset();
    step(1, 0, 1'b0);
    step(1, 1, 1'b1);
    n_checks++; if (bit_cnt !== 6'd0) $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); else n_pass++;
    n_checks++; if (digit !== 4'd0) $display("FAIL reset_digit got %0d want 0", digit); else n_pass++;
    n_checks++; if (inst !== 10'd0) $display("FAIL reset_inst got %h want 0", inst); else n_pass++;
    n_checks++; if (ptr !== 4'd3) $display("FAIL reset_ptr got %0d want 3", ptr); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid got %b want 0", inst_valid); else n_pass++;
    n_checks++; if (ptr_ovf !== 1'b0) $display("FAIL reset_ptr_ovf got %b want 0", ptr_ovf); else n_pass++;
    n_checks++; if (ws !== 1'b1) $display("FAIL reset_ws got %b want 1", ws); else n_pass++;
  endtask

  task automatic test_counters();
    int nsync, p;
    do_reset();
    nsync = 0;
    for (int k = 0; k < 2 * W; k++) begin
      p = k % W;
      if (sync === 1'b1) nsync++;
      n_checks++; if (bit_cnt !== 6'(p)) $display("FAIL cnt_bit_cnt k=%0d got %0d want %0d", k, bit_cnt, p); else n_pass++;
      n_checks++; if (digit !== 4'(p / 4)) $display("FAIL cnt_digit k=%0d got %0d want %0d", k, digit, p / 4); else n_pass++;
      n_checks++; if (sync !== ((p >= 45) && (p <= 54))) $display("FAIL cnt_sync k=%0d got %b", k, sync); else n_pass++;
      n_checks++; if (word_end !== (p == 55)) $display("FAIL cnt_word_end k=%0d got %b", k, word_end); else n_pass++;
      step(0, 1, logic'($urandom % 2));
    end
    n_checks++; if (nsync != 20) $display("FAIL cnt_sync_total got %0d want 20", nsync); else n_pass++;
  endtask

  task automatic test_p_field();
    logic [W-1:0] s0, s1;
    do_reset();
    run_word(10'b11111_000_10, s0);
    run_word(10'b0, s1);
    n_checks++; if (s0 !== {W{1'b1}}) $display("FAIL p_word0_ws got %h want all ones", s0); else n_pass++;
    n_checks++; if (s1 !== 56'h0000_0000_00F0_00) $display("FAIL p_word1_ws got %h want 00000000000f000", s1); else n_pass++;
  endtask

  task automatic test_set_wp();
    logic [W-1:0] s;
    do_reset();
    run_word(10'b1101_1100_00, s);
    n_checks++; if (ptr !== 4'd13) $display("FAIL set_ptr got %0d want 13", ptr); else n_pass++;
    run_word(10'b11111_100_10, s);
    run_word(10'b0, s);
    n_checks++; if (s !== {W{1'b1}}) $display("FAIL wp_ws got %h want all ones", s); else n_pass++;
  endtask

  task automatic test_inc_dec();
    logic [W-1:0] s;
    do_reset();
    run_word(10'b1101_1100_00, s);
    run_word(10'b0000_1101_00, s);
    n_checks++; if (ptr !== 4'd0) $display("FAIL inc_wrap got %0d want 0", ptr); else n_pass++;
    run_word(10'b0000_0111_00, s);
    n_checks++; if (ptr !== 4'd13) $display("FAIL dec_wrap got %0d want 13", ptr); else n_pass++;
  endtask

  task automatic test_ovf();
    logic [W-1:0] s;
    do_reset();
    run_word(10'b1111_1100_00, s);
    n_checks++; if (ptr !== 4'd3) $display("FAIL ovf_ptr got %0d want 3", ptr); else n_pass++;
    n_checks++; if (ptr_ovf !== 1'b1) $display("FAIL ovf_pulse got %b want 1", ptr_ovf); else n_pass++;
    n_checks++; if (inst_valid !== 1'b1) $display("FAIL ovf_inst_valid got %b want 1", inst_valid); else n_pass++;
    n_checks++; if (inst !== 10'b1111_1100_00) $display("FAIL ovf_inst got %b want 1111110000", inst); else n_pass++;
    step(0, 1, 1'b0);
    n_checks++; if (ptr_ovf !== 1'b0) $display("FAIL ovf_drop got %b want 0", ptr_ovf); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL iv_drop got %b want 0", inst_valid); else n_pass++;
  endtask

  task automatic test_ce_pause();
    logic [W-1:0] s;
    logic [9:0]   ins;
    ins = 10'b01011_001_10;
    do_reset();
    run_to(ins, 47);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, logic'($urandom % 2));
      n_checks++; if (bit_cnt !== 6'd47) $display("FAIL pause_bit_cnt k=%0d got %0d want 47", k, bit_cnt); else n_pass++;
      n_checks++; if (digit !== 4'd11 || sync !== 1'b1 || inst_valid !== 1'b0)
        $display("FAIL pause_state k=%0d got digit=%0d sync=%b iv=%b want 11/1/0", k, digit, sync, inst_valid);
      else n_pass++;
    end
    run_to(ins, 0);
    n_checks++; if (inst !== ins) $display("FAIL pause_inst got %b want %b", inst, ins); else n_pass++;
    run_word(10'b0, s);
    n_checks++; if (s !== 56'h0FFF_FFFF_FFF0_00) $display("FAIL pause_m_ws got %h want 0ffffffffff000", s); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s;
    do_reset();
    run_word(10'b0111_1100_00, s);
    run_word(10'b11111_000_10, s);
    n_checks++; if (ptr !== 4'd7) $display("FAIL rmid_pre_ptr got %0d want 7", ptr); else n_pass++;
    run_to(10'b00000_011_10, 50);
    step(1, 1, 1'b1);
    n_checks++; if (bit_cnt !== 6'd0 || ptr !== 4'd3) $display("FAIL rmid_reset got bit_cnt=%0d ptr=%0d want 0/3", bit_cnt, ptr); else n_pass++;
    run_word(10'b0, s);
    n_checks++; if (s !== {W{1'b1}}) $display("FAIL rmid_ws got %h want all ones", s); else n_pass++;
  endtask

  task automatic test_random();
    logic [9:0] ins;
    bit         c;
    do_reset();
    ins = rand_ins();
    for (int k = 0; k < 1800; k++) begin
      c = (($urandom % 8) != 0);
      step(0, c, pick_is(ins));
      if (m_wrap) ins = rand_ins();
      n_checks++;
      if (bit_cnt !== 6'(m_pos) || digit !== 4'(m_pos / DB) || sync !== in_sync(m_pos) ||
          word_end !== (m_pos == W - 1))
        $display("FAIL rnd_timing k=%0d got cnt=%0d dig=%0d sync=%b we=%b want pos %0d",
                 k, bit_cnt, digit, sync, word_end, m_pos);
      else n_pass++;
      n_checks++; if (ws !== exp_ws(m_pos / DB)) $display("FAIL rnd_ws k=%0d got %b want %b", k, ws, exp_ws(m_pos / DB)); else n_pass++;
      n_checks++; if (ptr !== 4'(m_ptr)) $display("FAIL rnd_ptr k=%0d got %0d want %0d", k, ptr, m_ptr); else n_pass++;
      n_checks++;
      if (inst !== m_inst || inst_valid !== m_iv || ptr_ovf !== m_ovf)
        $display("FAIL rnd_inst k=%0d got %h/%b/%b want %h/%b/%b", k, inst, inst_valid, ptr_ovf,
                 m_inst, m_iv, m_ovf);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; is = 1'b0;
    test_reset();
    test_counters();
    test_p_field();
    test_set_wp();
    test_inc_dec();
    test_ovf();
    test_ce_pause();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arc_ws_timing_gen.md
Name: arc_ws_timing_gen

Overview:
- Parametrised word-timing and word-select generator for the serial ARC datapath.
- Produces the bit/digit counters, the sync window and the serial instruction capture.
- Holds the pointer register, with set, increment and decrement operations.
- Drives `ws` to the ARC so that arithmetic instructions act only on their selected field, starting in the word after the instruction is received.
- Generalises the fixed 14-digit, pointer-fixed-at-3 timing to configurable word geometry, a live pointer and a clock-enable.

Parameters:
- DIGITS, 14, digits per word; range 4..16.
- DIGIT_BITS, 4, bits per digit; must be a power of two.
- IS_BITS, 10, instruction length in bits; must be ≥ 6 and < DIGITS*DIGIT_BITS-1.
- EXP_DIGITS, 3, exponent digits, including the exponent sign; must be < DIGITS-1.
- PTR_RST, 3, pointer value after reset; must be < DIGITS.

Ports:
- cph2  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  clock enable; when 0, all state holds.
- is  input  1  serial instruction bit, LSB first, sampled while sync=1.
- sync  output  1  instruction window.
- ws  output  1  word select to the ARC.
- bit_cnt  output  $clog2(DIGITS*DIGIT_BITS)  bit position in the word.
- digit  output  $clog2(DIGITS)  current digit; digit 0 is first (LS).
- word_end  output  1  high when bit_cnt = W-1.
- inst  output  IS_BITS  last captured instruction.
- inst_valid  output  1  one-cycle pulse when inst updates.
- ptr  output  $clog2(DIGITS)  pointer register.
- ptr_ovf  output  1  one-cycle pulse when a pointer set is rejected.

Behaviour:
- Definitions:
  - W = DIGITS*DIGIT_BITS.
  - All outputs are registered state or a combinational decode of registered state. There is no input-to-output combinational path except via registers.
- Reset (rst=1 at a clock edge, regardless of ce):
  - bit_cnt=0, digit=0, shift register=0, inst=0.
  - Arithmetic enable=0, ftype=0, ptr=PTR_RST.
  - inst_valid=0, ptr_ovf=0.
  - Reset mid-word abandons any partial instruction.
- Counters (ce=1):
  - bit_cnt increments and wraps from W-1 to 0.
  - digit = bit_cnt / DIGIT_BITS, kept as its own counter. It increments when the low log2(DIGIT_BITS) bits of bit_cnt are all 1, and wraps to 0 with bit_cnt.
- sync = 1 for bit_cnt in [W-IS_BITS-1, W-2] inclusive, i.e. exactly IS_BITS cycles (45..54 for defaults).
- Instruction capture:
  - On each sync cycle, is is shifted into an IS_BITS shift register: new bit enters at the MSB and contents shift toward the LSB.
  - After the window, bit 0 holds the first-received bit.
- Word end (word_end=1, ce=1): the shift register is loaded into inst, inst_valid pulses in the following cycle, and inst is decoded:
  - inst[1:0]=2'b10 (arithmetic): enable=1, ftype=inst[4:2].
  - Any other inst[1:0] clears enable. For inst[1:0]=2'b00, the pointer ops below apply.
  - inst[5:2]=4'b1100 (set): if inst[9:6] < DIGITS, ptr ← inst[9:6]. Otherwise ptr is unchanged and ptr_ovf pulses. Only bits [9:6] are used; IS_BITS must be ≥ 10 for this op.
  - inst[5:2]=4'b1101 (increment): ptr ← ptr+1, wrapping DIGITS-1 → 0.
  - inst[5:2]=4'b0111 (decrement): ptr ← ptr-1, wrapping 0 → DIGITS-1.
- Word select, with d = digit:
  - When enable=0: ws=1.
  - When enable=1, by ftype:
    - 000 P: d==ptr.
    - 001 M: EXP_DIGITS ≤ d ≤ DIGITS-2.
    - 010 X: d ≤ EXP_DIGITS-1.
    - 011 W: 1.
    - 100 WP: d ≤ ptr.
    - 101 MS: d ≥ EXP_DIGITS.
    - 110 XS: d == EXP_DIGITS-1.
    - 111 S: d == DIGITS-1.
- Latency: an instruction received in word N drives ws for all of word N+1. A pointer change at the end of word N is visible in word N+1's ws.
- ce=0: the counters, shift register, enable, ptr and inst all hold. inst_valid and ptr_ovf are forced to 0. sync, ws and word_end keep decoding the held state.

Test Plan:
- Reset, then ce=1 for 112 cycles → bit_cnt runs 0..55 twice; sync high for exactly bit_cnt 45..54; word_end high at 55; digit steps every 4 cycles.
- Word 0 serialises is=10'b11111_000_10 → word 1 has ws=1 only at bit_cnt 12..15 (ptr=3); word 0 itself has ws=1 throughout.
- Word 0 = set ptr 13 (10'b1101_1100_00), word 1 = [wp] arithmetic (10'b11111_100_10) → word 2 has ws=1 for all 56 bits.
- Word 0 = set ptr 13, word 1 = increment (10'b0000_1101_00) → ptr=0. Word 2 = decrement (10'b0000_0111_00) → ptr=13.
- Set ptr 15 (10'b1111_1100_00) → ptr stays 3; ptr_ovf pulses once the cycle after word_end; inst_valid pulses in that same cycle.
- ce=0 for 20 cycles at bit_cnt 47, mid-instruction → all state frozen; resume completes a correct capture. Separately, rst at bit_cnt 50 → the next word shows enable=0 (ws all 1), ptr=3, bit_cnt restarts at 0.
